// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Shares the GRF single write port between the in-order WB
//               stage (always wins, zero latency) and a deferred-result
//               requester queued through a small FIFO. Deferred entries are
//               drained in order on cycles where WB leaves the port idle.
//               Exports a pending-register mask and a starvation stall
//               request to the hazard unit, plus a sticky conflict flag.
// Ports       : clk, reset (async, active-high)
//               wb_en_in/wb_addr_in/wb_data_in        - WB write request
//               aux_valid_in/aux_addr_in/aux_data_in  - deferred write offer
//               aux_ready_out                         - FIFO accepts an entry
//               rf_we_out/rf_addr_out/rf_data_out     - GRF write port
//               pending_mask_out                      - registers with queued writes
//               stall_req_out                         - ask pipeline to bubble WB
//               conflict_out                          - sticky protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
  parameter int AUX_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_en_in,
  input  logic [4:0]  wb_addr_in,
  input  logic [31:0] wb_data_in,
  input  logic        aux_valid_in,
  input  logic [4:0]  aux_addr_in,
  input  logic [31:0] aux_data_in,
  output logic        aux_ready_out,
  output logic        rf_we_out,
  output logic [4:0]  rf_addr_out,
  output logic [31:0] rf_data_out,
  output logic [31:0] pending_mask_out,
  output logic        stall_req_out,
  output logic        conflict_out
);

  localparam int         c_PTR_W = (AUX_DEPTH > 1) ? $clog2(AUX_DEPTH) : 1;
  localparam int         c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(AUX_DEPTH);
  localparam logic [3:0]         c_LIMIT = 4'(STARVE_LIMIT);

  logic [4:0]         r_addr_q [AUX_DEPTH];
  logic [31:0]        r_data_q [AUX_DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [3:0]         r_starve;
  logic               r_stall;
  logic               r_conflict;

  logic               w_wb_active;
  logic               w_empty;
  logic               w_full;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic [c_CNT_W-1:0] w_count_next;
  logic [3:0]         w_starve_next;
  logic [31:0]        w_pending;

  assign w_wb_active   = wb_en_in && (wb_addr_in != 5'd0);
  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == c_FULL);
  // Ready is based on the registered count only, so a same-cycle pop never
  // opens a slot and there is no combinational path from WB to ready.
  assign aux_ready_out = !w_full && !reset;
  assign w_accept      = aux_valid_in && aux_ready_out;
  // Writes to r0 complete the handshake but are dropped.
  assign w_push        = w_accept && (aux_addr_in != 5'd0);
  assign w_pop         = !w_wb_active && !w_empty;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_starve_next = r_starve;
    if (w_pop || (w_count_next == '0)) begin
      w_starve_next = 4'd0;
    end else if (!w_empty && w_wb_active && (r_starve != c_LIMIT)) begin
      w_starve_next = r_starve + 4'd1;
    end
  end

  // Mask covers only the live window [rd_ptr, rd_ptr+count) of the ring.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < AUX_DEPTH; i++) begin
      if (c_CNT_W'(i) < r_count) begin
        w_pending[r_addr_q[r_rd_ptr + c_PTR_W'(i)]] = 1'b1;
      end
    end
    w_pending[0] = 1'b0;
  end

  always_comb begin
    rf_we_out   = 1'b0;
    rf_addr_out = 5'd0;
    rf_data_out = 32'd0;
    if (w_wb_active) begin
      rf_we_out   = 1'b1;
      rf_addr_out = wb_addr_in;
      rf_data_out = wb_data_in;
    end else if (!w_empty) begin
      rf_we_out   = 1'b1;
      rf_addr_out = r_addr_q[r_rd_ptr];
      rf_data_out = r_data_q[r_rd_ptr];
    end
  end

  // Entry storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_q[r_wr_ptr] <= aux_addr_in;
      r_data_q[r_wr_ptr] <= aux_data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_starve   <= 4'd0;
      r_stall    <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_next;
      r_starve   <= w_starve_next;
      r_stall    <= (w_starve_next == c_LIMIT);
      // WB hitting a queued register means the hazard unit failed; the WB
      // write still goes through, only the flag records it.
      r_conflict <= r_conflict | (w_wb_active && w_pending[wb_addr_in]);
    end
  end

  assign pending_mask_out = w_pending;
  assign stall_req_out    = r_stall;
  assign conflict_out     = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Scoreboard bench for rf_write_arbiter. Accepted deferred
//               writes are queued in a reference FIFO and compared when the
//               DUT presents them on the GRF port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

  localparam int c_DEPTH = 2;
  localparam int c_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_en_in;
  logic [4:0]  wb_addr_in;
  logic [31:0] wb_data_in;
  logic        aux_valid_in;
  logic [4:0]  aux_addr_in;
  logic [31:0] aux_data_in;
  logic        aux_ready_out;
  logic        rf_we_out;
  logic [4:0]  rf_addr_out;
  logic [31:0] rf_data_out;
  logic [31:0] pending_mask_out;
  logic        stall_req_out;
  logic        conflict_out;

  rf_write_arbiter #(.AUX_DEPTH(c_DEPTH), .STARVE_LIMIT(c_LIMIT)) u_dut (
    .clk              (clk),
    .reset            (reset),
    .wb_en_in         (wb_en_in),
    .wb_addr_in       (wb_addr_in),
    .wb_data_in       (wb_data_in),
    .aux_valid_in     (aux_valid_in),
    .aux_addr_in      (aux_addr_in),
    .aux_data_in      (aux_data_in),
    .aux_ready_out    (aux_ready_out),
    .rf_we_out        (rf_we_out),
    .rf_addr_out      (rf_addr_out),
    .rf_data_out      (rf_data_out),
    .pending_mask_out (pending_mask_out),
    .stall_req_out    (stall_req_out),
    .conflict_out     (conflict_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_cnt    = 0;
  logic m_stall  = 1'b0;
  logic m_conf   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (sb[k]) m[sb[k].a] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // Called at posedge+1: drive, check the cycle, advance the model across
  // the next edge, and return at the following posedge+1.
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      output logic acc);
    logic        act;
    logic        rdy;
    logic        pop;
    logic        ne;
    logic [31:0] msk;
    ent_t        h;
    wb_en_in = we; wb_addr_in = wa; wb_data_in = wd;
    aux_valid_in = av; aux_addr_in = aa; aux_data_in = ad;
    #1;
    act = we && (wa != 5'd0);
    rdy = (sb.size() < c_DEPTH);
    msk = model_mask();
    check("ready", 32'(aux_ready_out), 32'(rdy));
    check("mask", pending_mask_out, msk);
    check("stall", 32'(stall_req_out), 32'(m_stall));
    check("conflict", 32'(conflict_out), 32'(m_conf));
    if (act) begin
      check("wb_we", 32'(rf_we_out), 32'd1);
      check("wb_addr", 32'(rf_addr_out), 32'(wa));
      check("wb_data", rf_data_out, wd);
    end else if (sb.size() > 0) begin
      h = sb[0];
      check("aux_we", 32'(rf_we_out), 32'd1);
      check("aux_addr", 32'(rf_addr_out), 32'(h.a));
      check("aux_data", rf_data_out, h.d);
    end else begin
      check("idle_we", 32'(rf_we_out), 32'd0);
      check("idle_addr", 32'(rf_addr_out), 32'd0);
      check("idle_data", rf_data_out, 32'd0);
    end
    pop = !act && (sb.size() > 0);
    ne  = (sb.size() > 0);
    acc = av && rdy;
    if (act && msk[wa]) m_conf = 1'b1;
    if (pop) void'(sb.pop_front());
    if (acc && aa != 5'd0) sb.push_back('{a: aa, d: ad});
    if (pop || sb.size() == 0) m_cnt = 0;
    else if (ne && act && m_cnt < c_LIMIT) m_cnt++;
    m_stall = (m_cnt == c_LIMIT);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   guard;
    reset = 1'b1;
    wb_en_in = 1'b0; wb_addr_in = '0; wb_data_in = '0;
    aux_valid_in = 1'b0; aux_addr_in = '0; aux_data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(aux_ready_out), 32'd0);
    check("rst_we", 32'(rf_we_out), 32'd0);
    check("rst_mask", pending_mask_out, 32'd0);
    check("rst_stall", 32'(stall_req_out), 32'd0);
    check("rst_conflict", 32'(conflict_out), 32'd0);
    reset = 1'b0;

    // WB pass-through, no aux traffic
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, acc);
    // WB enabled to r0 is not a write
    step(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, acc);

    // Two back-to-back aux pushes with WB idle
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hAAAA, acc);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hBBBB, acc);
    idle(2);

    // Three offers with WB busy; third is refused until space frees
    step(1'b1, 5'd20, 32'h20, 1'b1, 5'd11, 32'h1111, acc);
    step(1'b1, 5'd21, 32'h21, 1'b1, 5'd12, 32'h2222, acc);
    for (int i = 0; i < 5; i++) step(1'b1, 5'd20 + 5'(i % 2), 32'h100 + 32'(i), 1'b1, 5'd13, 32'h3333, acc);
    guard = 0;
    acc = 1'b0;
    while (!acc && guard < 10) begin
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'h3333, acc);
      guard++;
    end
    check("r13_accepted", 32'(acc), 32'd1);
    idle(3);

    // Aux write to r0 is discarded
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555, acc);
    check("r0_handshake", 32'(acc), 32'd1);
    idle(1);

    // WB targets a queued register -> sticky conflict
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hA0A0, acc);
    step(1'b1, 5'd10, 32'hC0DE, 1'b0, 5'd0, 32'd0, acc);
    step(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, acc);
    idle(3);

    // Fill, starve into a stall, then reset asynchronously mid-cycle
    step(1'b1, 5'd20, 32'h1, 1'b1, 5'd1, 32'hF1, acc);
    step(1'b1, 5'd20, 32'h2, 1'b1, 5'd2, 32'hF2, acc);
    for (int i = 0; i < 5; i++) step(1'b1, 5'd22, 32'h3 + 32'(i), 1'b0, 5'd0, 32'd0, acc);
    check("pre_rst_stall", 32'(stall_req_out), 32'd1);
    wb_en_in = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_ready", 32'(aux_ready_out), 32'd0);
    check("arst_we", 32'(rf_we_out), 32'd0);
    check("arst_data", rf_data_out, 32'd0);
    check("arst_mask", pending_mask_out, 32'd0);
    check("arst_stall", 32'(stall_req_out), 32'd0);
    check("arst_conflict", 32'(conflict_out), 32'd0);
    sb.delete();
    m_cnt = 0; m_stall = 1'b0; m_conf = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
